// File: rtl/multicycle_control_unit.sv
// Main sequencing FSM for the multi-cycle RV32I core.
//
// state | meaning
// ------+--------------------------------------------------------------
//   0   | FETCH    : read instruction at PC, PC <= PC+4 when memory ready
//   1   | DECODE   : ALUOut <= oldPC + imm (branch/JAL target), dispatch
//   2   | MEMADR   : ALUOut <= rs1 + imm (load/store address)
//   3   | MEMREAD  : read data memory at ALUOut until ready
//   4   | MEMWB    : rd <= MDR
//   5   | MEMWRITE : write data memory at ALUOut until ready
//   6   | EXEC_R   : ALUOut <= rs1 op rs2
//   7   | EXEC_I   : ALUOut <= rs1 op imm
//   8   | ALUWB    : rd <= ALUOut
//   9   | BRANCH   : compare rs1/rs2, PC <= ALUOut if taken
//  10   | JAL      : PC <= ALUOut, rd <= PC (already oldPC+4)
//  11   | JALR     : PC <= rs1 + imm, rd <= PC
//  12   | AUIPC    : ALUOut <= oldPC + imm
//  13   | LUI      : ALUOut <= 0 + imm
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   instr_opcode_i    opcode field of the latched instruction
//   mem_ready_i       memory access completes this cycle
//   pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o,
//   ir_write_o, pc_source_o, alu_src_a_o, alu_src_b_o, alu_op_o,
//   reg_write_o, mem_to_reg_o   datapath controls
//   illegal_o         one-cycle pulse when DECODE sees an unknown opcode
//   state_o           current state (debug)
module multicycle_control_unit #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         instr_opcode_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               iord_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               pc_source_o,
  output logic [1:0]         alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         alu_op_o,
  output logic               reg_write_o,
  output logic [1:0]         mem_to_reg_o,
  output logic               illegal_o,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_AUIPC    = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t     state_q, state_d;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       pc_source, reg_write, illegal;
  logic [1:0] alu_src_a, alu_src_b, alu_op, mem_to_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    illegal       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready_i;
        pc_write  = mem_ready_i;
        state_d   = mem_ready_i ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (instr_opcode_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_LUI:            state_d = S_LUI;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (instr_opcode_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready_i ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready_i ? S_FETCH : S_MEMWRITE;
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 2'b01;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
      end
      S_JAL: begin
        // PC already advanced to oldPC+4 in FETCH, so it is the link value
        pc_write   = 1'b1;
        pc_source  = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
      end
      S_JALR: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates the controls combinationally so an in-flight memory strobe
  // drops in the same cycle rst rises.
  assign pc_write_o      = ~rst & pc_write;
  assign pc_write_cond_o = ~rst & pc_write_cond;
  assign iord_o          = ~rst & iord;
  assign mem_read_o      = ~rst & mem_read;
  assign mem_write_o     = ~rst & mem_write;
  assign ir_write_o      = ~rst & ir_write;
  assign pc_source_o     = ~rst & pc_source;
  assign alu_src_a_o     = rst ? 2'b00 : alu_src_a;
  assign alu_src_b_o     = rst ? 2'b00 : alu_src_b;
  assign alu_op_o        = rst ? 2'b00 : alu_op;
  assign reg_write_o     = ~rst & reg_write;
  assign mem_to_reg_o    = rst ? 2'b00 : mem_to_reg;
  assign illegal_o       = ~rst & illegal;
  assign state_o         = STATE_W'(state_q);

endmodule
